// File: rtl/ray_generator_if.sv
// Handshake and camera bundle between the ray generator and its frame controller / consumer.
// Vectors are packed as three DATA_W-bit fixed-point components, index 0 = x.
interface ray_generator_if #(
  parameter int DATA_W = 32,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180
);
  localparam int X_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic                   start_in;
  logic [2:0][DATA_W-1:0] forward_in;
  logic [2:0][DATA_W-1:0] right_step_in;
  logic [2:0][DATA_W-1:0] up_step_in;
  logic                   ready_in;
  logic                   valid_out;
  logic [2:0][DATA_W-1:0] dir_out;
  logic [X_W-1:0]         x_out;
  logic [Y_W-1:0]         y_out;
  logic                   busy_out;
  logic                   frame_done_out;

  modport master (
    input  start_in, forward_in, right_step_in, up_step_in, ready_in,
    output valid_out, dir_out, x_out, y_out, busy_out, frame_done_out
  );

  modport slave (
    output start_in, forward_in, right_step_in, up_step_in, ready_in,
    input  valid_out, dir_out, x_out, y_out, busy_out, frame_done_out
  );
endinterface

// File: rtl/ray_generator.sv
// Raster-order primary-ray direction generator: latches the camera basis on start and walks the
// screen by incremental accumulation, one unnormalized direction per pixel over valid/ready.
module ray_generator #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180
) (
  input logic           clk_in,
  input logic           rst_n_in,
  ray_generator_if.master rg
);
  localparam int X_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  typedef logic signed [DATA_W-1:0] fixed_t;
  typedef logic [2:0][DATA_W-1:0]   vec3_t;
  typedef enum logic [2:0] {IDLE, SETUP0, SETUP1, EMIT, DONE} state_t;

  function automatic fixed_t fadd(fixed_t a, fixed_t b);
    return a + b;
  endfunction

  function automatic fixed_t fsub(fixed_t a, fixed_t b);
    return a - b;
  endfunction

  // Full-precision product, then drop the fraction by arithmetic shift (rounds toward -inf).
  function automatic fixed_t fmul(fixed_t a, fixed_t b);
    logic signed [2*DATA_W-1:0] p;
    p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    return fixed_t'(p >>> FRAC_W);
  endfunction

  function automatic fixed_t to_fixed(int n);
    fixed_t v;
    v = fixed_t'(n);
    return v <<< FRAC_W;
  endfunction

  function automatic vec3_t vadd(vec3_t a, vec3_t b);
    vec3_t r;
    for (int i = 0; i < 3; i++) r[i] = fadd(a[i], b[i]);
    return r;
  endfunction

  function automatic vec3_t vsub(vec3_t a, vec3_t b);
    vec3_t r;
    for (int i = 0; i < 3; i++) r[i] = fsub(a[i], b[i]);
    return r;
  endfunction

  function automatic vec3_t vmul(vec3_t a, fixed_t s);
    vec3_t r;
    for (int i = 0; i < 3; i++) r[i] = fmul(a[i], s);
    return r;
  endfunction

  state_t         state;
  vec3_t          fwd, rstep, ustep, hx, hy, row_base, dir;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           valid, busy, frame_done;
  vec3_t          corner, next_row;

  assign corner   = vadd(vsub(fwd, hx), hy);
  assign next_row = vsub(row_base, ustep);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      fwd        <= '0;
      rstep      <= '0;
      ustep      <= '0;
      hx         <= '0;
      hy         <= '0;
      row_base   <= '0;
      dir        <= '0;
      x          <= '0;
      y          <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rg.start_in) begin
            fwd   <= rg.forward_in;
            rstep <= rg.right_step_in;
            ustep <= rg.up_step_in;
            busy  <= 1'b1;
            state <= SETUP0;
          end
        end
        SETUP0: begin
          hx    <= vmul(rstep, to_fixed(WIDTH / 2));
          hy    <= vmul(ustep, to_fixed(HEIGHT / 2));
          state <= SETUP1;
        end
        SETUP1: begin
          row_base <= corner;
          dir      <= corner;
          x        <= '0;
          y        <= '0;
          valid    <= 1'b1;
          state    <= EMIT;
        end
        EMIT: begin
          // Everything holds unless the current ray is taken this cycle.
          if (valid && rg.ready_in) begin
            if (x != X_LAST) begin
              dir <= vadd(dir, rstep);
              x   <= x + 1'b1;
            end else if (y != Y_LAST) begin
              row_base <= next_row;
              dir      <= next_row;
              x        <= '0;
              y        <= y + 1'b1;
            end else begin
              valid      <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rg.valid_out      = valid;
  assign rg.dir_out        = dir;
  assign rg.x_out          = x;
  assign rg.y_out          = y;
  assign rg.busy_out       = busy;
  assign rg.frame_done_out = frame_done;
endmodule

// File: tb/tb_ray_generator.sv
// Bench for ray_generator: three instances (4x2, 320x180, 3x1) checked against a closed-form
// per-pixel model in Q16.16, with random backpressure and random camera vectors.
module tb_ray_generator;
  typedef logic [2:0][31:0] vec_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in;
  logic start;
  logic ready;
  vec_t forward, rstep, ustep;
  int   sel;

  ray_generator_if #(.DATA_W(32), .WIDTH(4),   .HEIGHT(2))   ifa ();
  ray_generator_if #(.DATA_W(32), .WIDTH(320), .HEIGHT(180)) ifb ();
  ray_generator_if #(.DATA_W(32), .WIDTH(3),   .HEIGHT(1))   ifc ();

  assign ifa.start_in = start && (sel == 0);
  assign ifb.start_in = start && (sel == 1);
  assign ifc.start_in = start && (sel == 2);
  assign ifa.forward_in = forward;  assign ifb.forward_in = forward;  assign ifc.forward_in = forward;
  assign ifa.right_step_in = rstep; assign ifb.right_step_in = rstep; assign ifc.right_step_in = rstep;
  assign ifa.up_step_in = ustep;    assign ifb.up_step_in = ustep;    assign ifc.up_step_in = ustep;
  assign ifa.ready_in = ready;      assign ifb.ready_in = ready;      assign ifc.ready_in = ready;

  ray_generator #(.DATA_W(32), .FRAC_W(16), .WIDTH(4), .HEIGHT(2)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rg(ifa.master));
  ray_generator #(.DATA_W(32), .FRAC_W(16), .WIDTH(320), .HEIGHT(180)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rg(ifb.master));
  ray_generator #(.DATA_W(32), .FRAC_W(16), .WIDTH(3), .HEIGHT(1)) dut_c (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rg(ifc.master));

  logic m_valid, m_busy, m_done;
  vec_t m_dir;
  int   m_x, m_y;

  always_comb begin
    m_valid = ifc.valid_out; m_busy = ifc.busy_out; m_done = ifc.frame_done_out;
    m_dir = ifc.dir_out; m_x = int'(ifc.x_out); m_y = int'(ifc.y_out);
    if (sel == 0) begin
      m_valid = ifa.valid_out; m_busy = ifa.busy_out; m_done = ifa.frame_done_out;
      m_dir = ifa.dir_out; m_x = int'(ifa.x_out); m_y = int'(ifa.y_out);
    end else if (sel == 1) begin
      m_valid = ifb.valid_out; m_busy = ifb.busy_out; m_done = ifb.frame_done_out;
      m_dir = ifb.dir_out; m_x = int'(ifb.x_out); m_y = int'(ifb.y_out);
    end
  end

  int checks = 0;
  int passed = 0;

  int   q_x[$], q_y[$];
  vec_t q_dir[$];
  vec_t ref_seq[$];
  int   stall_viol, valid_gaps;
  bit   timed_out;

  function automatic vec_t mkvec(real a, real b, real c);
    vec_t v;
    v[0] = int'(a * 65536.0);
    v[1] = int'(b * 65536.0);
    v[2] = int'(c * 65536.0);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 3; i++) v[i] = $urandom;
    return v;
  endfunction

  // Components within +/-4.0 so every pixel direction stays representable.
  function automatic vec_t small_vec();
    vec_t v;
    for (int i = 0; i < 3; i++) v[i] = int'($urandom_range(0, 1 << 19)) - (1 << 18);
    return v;
  endfunction

  function automatic vec_t model_dir(int w, int h, int x, int y, vec_t f, vec_t r, vec_t u);
    vec_t   v;
    longint c;
    for (int i = 0; i < 3; i++) begin
      c = longint'($signed(f[i])) + longint'($signed(r[i])) * longint'(x - w / 2)
        + longint'($signed(u[i])) * longint'(h / 2 - y);
      v[i] = c[31:0];
    end
    return v;
  endfunction

  task automatic start_frame(output bit b_n, output bit v_n1, output bit v_n2, output vec_t d_n2);
    ready = 1'b0;
    @(negedge clk_in);
    start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
    b_n = m_busy;
    @(posedge clk_in);
    #1 v_n1 = m_valid;
    @(posedge clk_in);
    #1 v_n2 = m_valid;
    d_n2 = m_dir;
  endtask

  // Records transfers, stall stability and valid gaps until frame_done is seen or the budget runs out.
  task automatic collect(input bit rand_ready, input bit disturb, input int max_cycles);
    bit   prev_stall = 1'b0;
    bit   done_seen = 1'b0;
    vec_t pd = '0;
    int   px = 0, py = 0, n = 0;
    q_x.delete(); q_y.delete(); q_dir.delete();
    stall_viol = 0; valid_gaps = 0; timed_out = 1'b0;
    while (!done_seen && n < max_cycles) begin
      @(negedge clk_in);
      n++;
      if (prev_stall && (m_valid !== 1'b1 || m_dir !== pd || m_x != px || m_y != py)) stall_viol++;
      if (m_done === 1'b1) done_seen = 1'b1;
      else if (m_valid !== 1'b1) valid_gaps++;
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb) begin
        start   = done_seen ? 1'b1 : 1'($urandom_range(0, 1));
        forward = rand_vec();
      end
      if (m_valid === 1'b1 && ready) begin
        q_x.push_back(m_x); q_y.push_back(m_y); q_dir.push_back(m_dir);
      end
      prev_stall = (m_valid === 1'b1) && !ready;
      pd = m_dir; px = m_x; py = m_y;
    end
    if (!done_seen) timed_out = 1'b1;
  endtask

  task automatic set_std_vectors();
    forward = mkvec(0.0, 0.0, 1.0);
    rstep   = mkvec(0.25, 0.0, 0.0);
    ustep   = mkvec(0.0, 0.25, 0.0);
  endtask

  task automatic test_reset();
    bit b, v1, v2; vec_t d; int bad = 0;
    sel = 0; start = 1'b0; ready = 1'b0; set_std_vectors();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0)
      $display("FAIL reset_ctrl valid/busy/done=%b%b%b want 000", m_valid, m_busy, m_done); else passed++;
    checks++; if (m_dir !== '0 || m_x != 0 || m_y != 0)
      $display("FAIL reset_data dir=%h x=%0d y=%0d want 0", m_dir, m_x, m_y); else passed++;
    @(negedge clk_in) rst_n_in = 1'b1;
    start_frame(b, v1, v2, d);
    @(negedge clk_in) ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0)
      $display("FAIL async_reset_ctrl valid/busy/done=%b%b%b want 000", m_valid, m_busy, m_done); else passed++;
    checks++; if (m_dir !== '0 || m_x != 0 || m_y != 0)
      $display("FAIL async_reset_data dir=%h x=%0d y=%0d want 0", m_dir, m_x, m_y); else passed++;
    @(negedge clk_in) rst_n_in = 1'b1;
    repeat (20) begin
      @(negedge clk_in);
      if (m_valid !== 1'b0 || m_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL post_reset_idle active_cycles=%0d want 0", bad); else passed++;
  endtask

  task automatic test_small_frame();
    bit b, v1, v2; vec_t d; int bad = 0;
    vec_t corners[4];
    sel = 0; set_std_vectors();
    corners[0] = mkvec(-0.5, 0.25, 1.0); corners[1] = mkvec(0.25, 0.25, 1.0);
    corners[2] = mkvec(-0.5, 0.0, 1.0);  corners[3] = mkvec(0.25, 0.0, 1.0);
    start_frame(b, v1, v2, d);
    checks++; if (b !== 1'b1) $display("FAIL busy_after_start got %b want 1", b); else passed++;
    checks++; if (v1 !== 1'b0) $display("FAIL valid_after_N1 got %b want 0", v1); else passed++;
    checks++; if (v2 !== 1'b1 || d !== corners[0])
      $display("FAIL first_valid_N2 valid=%b dir=%h want 1 %h", v2, d, corners[0]); else passed++;
    collect(1'b0, 1'b0, 100);
    checks++; if (timed_out || q_dir.size() != 8 || valid_gaps != 0)
      $display("FAIL small_count timeout=%0d n=%0d gaps=%0d want 0 8 0", timed_out, q_dir.size(), valid_gaps);
    else passed++;
    for (int i = 0; i < q_dir.size() && i < 8; i++)
      if (q_x[i] != i % 4 || q_y[i] != i / 4 ||
          q_dir[i] !== model_dir(4, 2, i % 4, i / 4, forward, rstep, ustep)) bad++;
    checks++; if (bad != 0) $display("FAIL small_raster bad_pixels=%0d want 0", bad); else passed++;
    if (q_dir.size() == 8) begin
      checks++; if (q_dir[0] !== corners[0]) $display("FAIL px00 got %h want %h", q_dir[0], corners[0]); else passed++;
      checks++; if (q_dir[3] !== corners[1]) $display("FAIL px30 got %h want %h", q_dir[3], corners[1]); else passed++;
      checks++; if (q_dir[4] !== corners[2]) $display("FAIL px01 got %h want %h", q_dir[4], corners[2]); else passed++;
      checks++; if (q_dir[7] !== corners[3]) $display("FAIL px31 got %h want %h", q_dir[7], corners[3]); else passed++;
    end
    ref_seq = q_dir;
    @(negedge clk_in);
    checks++; if (m_done !== 1'b0 || m_busy !== 1'b0)
      $display("FAIL done_single_pulse done=%b busy=%b want 0 0", m_done, m_busy); else passed++;
  endtask

  task automatic test_backpressure();
    bit b, v1, v2; vec_t d; int bad = 0;
    sel = 0; set_std_vectors();
    start_frame(b, v1, v2, d);
    collect(1'b1, 1'b0, 400);
    checks++; if (timed_out || stall_viol != 0 || valid_gaps != 0)
      $display("FAIL bp_stall timeout=%0d unstable=%0d drops=%0d want 0 0 0", timed_out, stall_viol, valid_gaps);
    else passed++;
    checks++; if (q_dir.size() != 8) $display("FAIL bp_count got %0d want 8", q_dir.size()); else passed++;
    for (int i = 0; i < q_dir.size() && i < ref_seq.size(); i++)
      if (q_dir[i] !== ref_seq[i] || q_x[i] != i % 4 || q_y[i] != i / 4) bad++;
    checks++; if (bad != 0) $display("FAIL bp_sequence bad=%0d want 0", bad); else passed++;
    @(negedge clk_in);
  endtask

  task automatic test_ignored_start();
    bit b, v1, v2; vec_t d; int bad = 0;
    sel = 0; set_std_vectors();
    start_frame(b, v1, v2, d);
    collect(1'b1, 1'b1, 400);
    for (int i = 0; i < q_dir.size() && i < ref_seq.size(); i++) if (q_dir[i] !== ref_seq[i]) bad++;
    checks++; if (timed_out || q_dir.size() != 8 || bad != 0)
      $display("FAIL disturbed_frame timeout=%0d n=%0d bad=%0d want 0 8 0", timed_out, q_dir.size(), bad);
    else passed++;
    @(negedge clk_in);
    checks++; if (m_busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL start_in_done_ignored busy=%b valid=%b want 0 0", m_busy, m_valid); else passed++;
    set_std_vectors(); ready = 1'b0; start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
    checks++; if (m_busy !== 1'b1) $display("FAIL restart_M2 busy=%b want 1", m_busy); else passed++;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    checks++; if (m_valid !== 1'b1 || m_dir !== ref_seq[0])
      $display("FAIL restart_first valid=%b dir=%h want 1 %h", m_valid, m_dir, ref_seq[0]); else passed++;
    collect(1'b0, 1'b0, 100);
    bad = 0;
    for (int i = 0; i < q_dir.size() && i < ref_seq.size(); i++) if (q_dir[i] !== ref_seq[i]) bad++;
    checks++; if (timed_out || q_dir.size() != 8 || bad != 0)
      $display("FAIL restart_frame timeout=%0d n=%0d bad=%0d want 0 8 0", timed_out, q_dir.size(), bad);
    else passed++;
    @(negedge clk_in);
  endtask

  task automatic test_random_camera();
    bit b, v1, v2; vec_t d;
    sel = 0;
    for (int k = 0; k < 3; k++) begin
      int bad = 0;
      forward = small_vec(); rstep = small_vec(); ustep = small_vec();
      start_frame(b, v1, v2, d);
      collect(1'b1, 1'b0, 400);
      for (int i = 0; i < q_dir.size(); i++)
        if (q_dir[i] !== model_dir(4, 2, i % 4, i / 4, forward, rstep, ustep)) bad++;
      checks++; if (timed_out || q_dir.size() != 8 || bad != 0 || stall_viol != 0)
        $display("FAIL random_cam%0d timeout=%0d n=%0d bad=%0d unstable=%0d want 0 8 0 0",
                 k, timed_out, q_dir.size(), bad, stall_viol);
      else passed++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_full_frame();
    bit b, v1, v2; vec_t d; int bad = 0; int n;
    vec_t last_want;
    sel = 1; set_std_vectors();
    last_want = mkvec(39.75, -22.25, 1.0);
    start_frame(b, v1, v2, d);
    collect(1'b0, 1'b0, 60000);
    n = q_dir.size();
    checks++; if (timed_out || n != 57600 || valid_gaps != 0)
      $display("FAIL full_count timeout=%0d n=%0d gaps=%0d want 0 57600 0", timed_out, n, valid_gaps);
    else passed++;
    for (int i = 0; i < n; i++)
      if (q_x[i] != i % 320 || q_y[i] != i / 320 ||
          q_dir[i] !== model_dir(320, 180, i % 320, i / 320, forward, rstep, ustep)) bad++;
    checks++; if (bad != 0) $display("FAIL full_pixels bad=%0d want 0", bad); else passed++;
    if (n > 0) begin
      checks++; if (q_dir[n-1] !== last_want || q_x[n-1] != 319 || q_y[n-1] != 179)
        $display("FAIL full_last dir=%h x=%0d y=%0d want %h 319 179", q_dir[n-1], q_x[n-1], q_y[n-1], last_want);
      else passed++;
    end
    @(negedge clk_in);
  endtask

  task automatic test_odd_size();
    bit b, v1, v2; vec_t d;
    vec_t want[3];
    sel = 2; set_std_vectors();
    want[0] = mkvec(-0.25, 0.0, 1.0); want[1] = mkvec(0.0, 0.0, 1.0); want[2] = mkvec(0.25, 0.0, 1.0);
    start_frame(b, v1, v2, d);
    collect(1'b1, 1'b0, 100);
    checks++; if (timed_out || q_dir.size() != 3)
      $display("FAIL odd_count timeout=%0d n=%0d want 0 3", timed_out, q_dir.size()); else passed++;
    for (int i = 0; i < q_dir.size() && i < 3; i++) begin
      checks++; if (q_dir[i] !== want[i] || q_x[i] != i || q_y[i] != 0)
        $display("FAIL odd_px%0d dir=%h x=%0d y=%0d want %h %0d 0", i, q_dir[i], q_x[i], q_y[i], want[i], i);
      else passed++;
    end
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_backpressure();
    test_ignored_start();
    test_random_camera();
    test_full_frame();
    test_odd_size();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
